spi_instr_fetch: RTL and testbench
==================================

Name: spi_instr_fetch

Overview:
- SPI-slave front end that feeds the instruction decoder.
- Deserialises bytes arriving on MOSI and splits each byte into a 4-bit opcode (high nibble) and a 4-bit operand (low nibble).
- Buffers decoded pairs in a small FIFO and presents them downstream with a valid/ready handshake.
- Shifts an 8-bit result byte, supplied by the datapath, back out on MISO.

Parameters:
- FIFO_DEPTH, 4, number of instruction entries buffered; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages synchronising spi_sclk, spi_mosi and spi_cs_n into clk; minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- spi_sclk  input  1  SPI clock, asynchronous to clk.
- spi_mosi  input  1  SPI data in.
- spi_cs_n  input  1  SPI chip select, active low.
- spi_miso  output  1  SPI data out.
- instructionOut  output  4  opcode at FIFO head; goes to the decoder instructionIn.
- operandOut  output  4  operand at FIFO head.
- instr_valid  output  1  FIFO head holds a valid entry.
- instr_ready  input  1  consumer accepts the head entry this cycle.
- result_in  input  8  result byte to return over SPI.
- result_load  input  1  capture result_in into the result holding register.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- busy  output  1  synchronised CS is active (low).

Behaviour:
- Reset values: spi_miso=0, instr_valid=0, instructionOut=0, operandOut=0, overflow=0, busy=0. Bit counter, FIFO pointers/count, rx/tx shift registers and result holding register are all 0.
- Synchronisation: all three SPI inputs pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronised stage with one extra registered copy.
- Edge latency: a pin edge becomes an internal edge pulse SYNC_STAGES+1 clk cycles later.
- Clock ratio: clk must be at least 4x sclk; this is a usage requirement and is not checked.
- SPI mode 0, MSB first:
  - Rising sclk edge with CS active: shift the synchronised MOSI into rx_shift and increment bit_cnt (3 bits).
  - Falling sclk edge with CS active: shift tx_shift left by one; spi_miso = tx_shift[7] after the shift.
- Byte completion: on the rising edge where bit_cnt goes 7->0, the assembled byte B is pushed as {opcode=B[7:4], operand=B[3:0]}. Several consecutive bytes per CS frame are allowed.
- CS falling edge:
  - bit_cnt=0, rx_shift=0.
  - tx_shift = result holding register; spi_miso = its bit 7 from the next cycle.
- CS rising edge mid-byte: the partial byte is discarded and bit_cnt resets to 0. No push.
- CS high: spi_miso=0; sclk edges are ignored.
- result_load: the holding register updates on the next clk edge. A load during an active frame does not affect tx_shift until the next CS falling edge.
- FIFO:
  - Pointer-based storage of FIFO_DEPTH x 8 bits.
  - instr_valid = count!=0.
  - instructionOut/operandOut show the head entry, driven from storage; they read 0 when empty.
  - Pop when instr_valid && instr_ready.
  - instr_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Push into an empty FIFO: instr_valid rises on the following cycle. There is no same-cycle bypass.
- Push and pop in the same cycle:
  - Always legal, including when full: the pop frees the slot and the push is accepted.
  - count is unchanged.
- Push when full without a simultaneous pop: the byte is dropped, storage is untouched, and overflow is set. overflow clears only on reset.
- busy = inverted synchronised CS.
- Reset during an active frame clears all state on that clk edge. Reception restarts only at the next CS falling edge; sclk edges before that edge are ignored even if CS is low.

Test Plan:
- Single byte: CS low, send 0xA5, CS high. Expect instr_valid=1 with instructionOut=0xA and operandOut=0x5, stable until instr_ready is held 1 cycle; then instr_valid=0.
- Burst: in one frame send 0x10, 0x2F, 0xC3, 0x07 with instr_ready=0. Expect count=4 and overflow=0. Then pop with ready held high; the order must be (1,0), (2,F), (C,3), (0,7).
- Overflow: with ready=0 send 5 bytes 0x01..0x05. Expect overflow=1 and the FIFO holds 0x01..0x04. Repeat with ready pulsed exactly on the cycle the 5th byte completes: expect all 5 bytes delivered and overflow=0.
- MISO readback: result_in=0x96 with result_load pulsed, then one 8-bit frame. The MISO bits sampled on sclk rising edges must be 1,0,0,1,0,1,1,0; spi_miso=0 after CS high.
- Aborted byte: CS low, 5 clock pulses, CS high, then a full 0x3C frame. Expect exactly one entry (3,C) and no push from the partial byte.
- Reset mid-frame: assert reset after 4 bits of a byte, release it, then send a fresh frame carrying 0xE1. Expect all outputs at reset values, the FIFO empty, and then a single entry (E,1).

Source files
------------

// File: rtl/spi_instr_fetch.sv
// rtl/spi_instr_fetch.sv - SPI-slave instruction fetch front end with FIFO and MISO readback
// Bytes on MOSI become {opcode, operand} FIFO entries; a held result byte shifts out on MISO.
module spi_instr_fetch #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic [3:0] instructionOut,
  output logic [3:0] operandOut,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic [7:0] result_in,
  input  logic       result_load,
  output logic       overflow,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_CYCLES = PW'(SYNC_STAGES + 1);
  localparam logic [AW:0]   FULL_COUNT   = (AW+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic [PW-1:0]          prime_cnt;
  logic                   frame_active;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift, result_reg;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;

  logic       sclk_s, mosi_s, cs_s, primed;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic       push, pop, full, accept;
  logic [7:0] rx_byte;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // Edges are ignored until the synchroniser has refilled after reset, so a
  // CS already low at reset release does not look like a fresh frame start.
  assign primed    = prime_cnt == PRIME_CYCLES;
  assign cs_fall   = primed && !cs_s && cs_d;
  assign cs_rise   = primed && cs_s && !cs_d;
  assign sclk_rise = frame_active && !cs_s && sclk_s && !sclk_d;
  assign sclk_fall = frame_active && !cs_s && !sclk_s && sclk_d;

  assign rx_byte = {rx_shift[6:0], mosi_s};
  assign push    = sclk_rise && (bit_cnt == 3'd7);
  assign full    = count == FULL_COUNT;
  assign instr_valid = count != '0;
  assign pop     = instr_valid && instr_ready;
  assign accept  = push && (!full || pop);

  assign instructionOut = instr_valid ? mem[rd_ptr][7:4] : 4'd0;
  assign operandOut     = instr_valid ? mem[rd_ptr][3:0] : 4'd0;
  assign busy           = !cs_s;

  always_ff @(posedge clk) begin
    if (!reset && accept) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync    <= '0;
      mosi_sync    <= '0;
      cs_sync      <= '1;
      sclk_d       <= 1'b0;
      cs_d         <= 1'b1;
      prime_cnt    <= '0;
      frame_active <= 1'b0;
      bit_cnt      <= 3'd0;
      rx_shift     <= 8'd0;
      tx_shift     <= 8'd0;
      spi_miso     <= 1'b0;
      result_reg   <= 8'd0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      if (result_load) result_reg <= result_in;

      if (cs_fall) begin
        frame_active <= 1'b1;
        bit_cnt      <= 3'd0;
        rx_shift     <= 8'd0;
        tx_shift     <= result_reg;
        spi_miso     <= result_reg[7];
      end else if (cs_rise || !frame_active) begin
        frame_active <= 1'b0;
        bit_cnt      <= 3'd0;
        spi_miso     <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (sclk_fall) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          spi_miso <= tx_shift[6];
        end
      end

      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop) count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_instr_fetch.sv
// tb/tb_spi_instr_fetch.sv - directed self-checking bench for spi_instr_fetch
// SPI pins are driven at 1/8 of clk; outputs are sampled 1 ns after the clk edge.
module tb_spi_instr_fetch;
  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_mosi, spi_cs_n, spi_miso;
  logic [3:0] instructionOut, operandOut;
  logic       instr_valid, instr_ready;
  logic [7:0] result_in;
  logic       result_load, overflow, busy;
  logic [7:0] miso_cap;
  int         checks = 0;
  int         errors = 0;

  spi_instr_fetch dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .instructionOut(instructionOut), .operandOut(operandOut),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .result_in(result_in), .result_load(result_load),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {valid, opcode, operand}: e.g. 0x1A5 for a valid (A,5) head, 0x000 when empty
  function automatic logic [31:0] head();
    return {23'd0, instr_valid, instructionOut, operandOut};
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic cs_set(input logic v);
    spi_cs_n = v;
    wait_cycles(6);
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    wait_cycles(4);
    miso_cap = {miso_cap[6:0], spi_miso};
    spi_sclk = 1'b1;
    wait_cycles(4);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    wait_cycles(4);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, head(), exp);
    instr_ready = 1'b1;
    wait_cycles(1);
    instr_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b5;
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    instr_ready = 1'b0; result_in = 8'd0; result_load = 1'b0; miso_cap = 8'd0;
    wait_cycles(3);
    check("reset_outputs", {26'd0, spi_miso, instr_valid, instructionOut != 4'd0,
                            operandOut != 4'd0, overflow, busy}, 32'd0);
    reset = 1'b0;
    wait_cycles(5);

    // single byte
    cs_set(1'b0);
    check("busy_active", 32'(busy), 32'd1);
    spi_byte(8'hA5);
    cs_set(1'b1);
    check("busy_idle", 32'(busy), 32'd0);
    check("single_head", head(), 32'h1A5);
    wait_cycles(5);
    check("single_stable", head(), 32'h1A5);
    pop_check("single_pop", 32'h1A5);
    check("single_empty", head(), 32'h000);

    // burst of four in one frame, then drain with ready held
    cs_set(1'b0);
    spi_byte(8'h10); spi_byte(8'h2F); spi_byte(8'hC3); spi_byte(8'h07);
    cs_set(1'b1);
    check("burst_count", 32'(dut.count), 32'd4);
    check("burst_no_ovf", 32'(overflow), 32'd0);
    instr_ready = 1'b1;
    check("burst_0", head(), 32'h110);
    wait_cycles(1); check("burst_1", head(), 32'h12F);
    wait_cycles(1); check("burst_2", head(), 32'h1C3);
    wait_cycles(1); check("burst_3", head(), 32'h107);
    wait_cycles(1); check("burst_empty", head(), 32'h000);
    instr_ready = 1'b0;

    // overflow: fifth byte dropped
    cs_set(1'b0);
    for (int i = 1; i <= 5; i++) spi_byte(8'(i));
    cs_set(1'b1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(dut.count), 32'd4);
    pop_check("ovf_pop1", 32'h101);
    pop_check("ovf_pop2", 32'h102);
    pop_check("ovf_pop3", 32'h103);
    pop_check("ovf_pop4", 32'h104);
    check("ovf_empty", head(), 32'h000);

    reset = 1'b1; wait_cycles(2); reset = 1'b0; wait_cycles(5);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO with a pop in the same cycle as the fifth push
    cs_set(1'b0);
    for (int i = 1; i <= 4; i++) spi_byte(8'(i));
    b5 = 8'h05;
    for (int i = 7; i >= 1; i--) spi_bit(b5[i]);
    spi_mosi = b5[0];
    wait_cycles(4);
    spi_sclk = 1'b1;
    wait_cycles(2);
    check("simul_head", head(), 32'h101);
    instr_ready = 1'b1;
    wait_cycles(1);
    instr_ready = 1'b0;
    check("simul_count", 32'(dut.count), 32'd4);
    check("simul_no_ovf", 32'(overflow), 32'd0);
    wait_cycles(2);
    spi_sclk = 1'b0;
    wait_cycles(4);
    cs_set(1'b1);
    pop_check("simul_pop2", 32'h102);
    pop_check("simul_pop3", 32'h103);
    pop_check("simul_pop4", 32'h104);
    pop_check("simul_pop5", 32'h105);
    check("simul_empty", head(), 32'h000);
    check("simul_ovf_end", 32'(overflow), 32'd0);

    // MISO readback
    result_in = 8'h96; result_load = 1'b1;
    wait_cycles(1);
    result_load = 1'b0; result_in = 8'h00;
    cs_set(1'b0);
    spi_byte(8'h00);
    check("miso_bits", 32'(miso_cap), 32'h96);
    cs_set(1'b1);
    check("miso_idle", 32'(spi_miso), 32'd0);
    pop_check("miso_rx", 32'h100);

    // aborted partial byte
    cs_set(1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_set(1'b1);
    check("abort_no_push", head(), 32'h000);
    cs_set(1'b0);
    spi_byte(8'h3C);
    cs_set(1'b1);
    check("abort_count", 32'(dut.count), 32'd1);
    pop_check("abort_entry", 32'h13C);
    check("abort_empty", head(), 32'h000);

    // reset in the middle of a frame
    cs_set(1'b0);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    reset = 1'b1;
    wait_cycles(1);
    check("rst_outputs", {26'd0, spi_miso, instr_valid, instructionOut != 4'd0,
                          operandOut != 4'd0, overflow, busy}, 32'd0);
    check("rst_count", 32'(dut.count), 32'd0);
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(5);
    spi_byte(8'hFF);
    check("rst_ignore_sclk", head(), 32'h000);
    cs_set(1'b1);
    cs_set(1'b0);
    spi_byte(8'hE1);
    cs_set(1'b1);
    check("rst_count_after", 32'(dut.count), 32'd1);
    pop_check("rst_entry", 32'h1E1);
    check("rst_empty", head(), 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
